// File: rtl/step_controller.sv
// Debounced single-step / run controller that gates the CPU datapath clock enable.
// Define STEP_BREAKPOINT_EN to compile in breakpoint halting (BREAK state, resume mask).
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic i_oszClk,
  input  logic i_btnReset,
  input  logic i_btnStep,
  input  logic i_swInstrNCycle,
  input  logic i_swStepNRun,
  input  logic i_swEnableBreakpoint,
  input  logic i_instrDone,
  input  logic i_breakpointHit,
  output logic o_cpuClkEn,
  output logic o_halted,
  output logic o_breakActive
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, STEP_CYC, STEP_INS, RUN, BREAK} stateT;

  logic [1:0] btnSync, instrSync, stepSync, syncVld;
  logic btnS, instrS, stepS;

  // syncVld marks when the synchronizer outputs reflect real inputs rather than reset zeros
  always_ff @(posedge i_oszClk) begin
    if (i_btnReset) begin
      btnSync   <= '0;
      instrSync <= '0;
      stepSync  <= '0;
      syncVld   <= '0;
    end else begin
      btnSync   <= {btnSync[0], i_btnStep};
      instrSync <= {instrSync[0], i_swInstrNCycle};
      stepSync  <= {stepSync[0], i_swStepNRun};
      syncVld   <= {syncVld[0], 1'b1};
    end
  end

  assign btnS   = btnSync[1];
  assign instrS = instrSync[1];
  assign stepS  = stepSync[1];

  logic [CW-1:0] dbCnt;
  logic dbLevel, armed, pressPulse;

  // armed stays low until the button is seen released, so a button held through reset is ignored
  always_ff @(posedge i_oszClk) begin
    if (i_btnReset) begin
      dbCnt      <= '0;
      dbLevel    <= 1'b0;
      armed      <= 1'b0;
      pressPulse <= 1'b0;
    end else begin
      pressPulse <= 1'b0;
      if (btnS == dbLevel) begin
        dbCnt <= '0;
      end else if (dbCnt == CNT_LAST) begin
        dbCnt      <= '0;
        dbLevel    <= ~dbLevel;
        pressPulse <= ~dbLevel & armed;
      end else begin
        dbCnt <= dbCnt + CW'(1);
      end
      if (syncVld[1] && !btnS && !dbLevel) armed <= 1'b1;
    end
  end

  logic bpTake;

`ifdef STEP_BREAKPOINT_EN
  logic [1:0] bpEnSync;
  logic bpMask;

  always_ff @(posedge i_oszClk) begin
    if (i_btnReset) bpEnSync <= '0;
    else            bpEnSync <= {bpEnSync[0], i_swEnableBreakpoint};
  end

  assign bpTake = bpEnSync[1] && i_breakpointHit && i_instrDone && !bpMask;
`else
  logic unusedBp;
  assign unusedBp = i_swEnableBreakpoint ^ i_breakpointHit;
  assign bpTake   = 1'b0;
`endif

  stateT state, nextState;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (syncVld[1]) begin
          if (!stepS)          nextState = RUN;
          else if (pressPulse) nextState = instrS ? STEP_INS : STEP_CYC;
        end
      end
      STEP_CYC: nextState = IDLE;
      STEP_INS: if (i_instrDone) nextState = IDLE;
      RUN: begin
        // leaving run in instruction mode finishes the current instruction first
        if (stepS) begin
          if (!instrS || i_instrDone) nextState = IDLE;
          else                        nextState = STEP_INS;
        end else if (bpTake) begin
          nextState = BREAK;
        end
      end
`ifdef STEP_BREAKPOINT_EN
      BREAK: begin
        if (stepS)           nextState = IDLE;
        else if (pressPulse) nextState = RUN;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_oszClk) begin
    if (i_btnReset) begin
      state      <= IDLE;
      o_cpuClkEn <= 1'b0;
      o_halted   <= 1'b1;
    end else begin
      state      <= nextState;
      o_cpuClkEn <= nextState inside {STEP_CYC, STEP_INS, RUN};
      o_halted   <= nextState inside {IDLE, BREAK};
    end
  end

`ifdef STEP_BREAKPOINT_EN
  // mask lets the resumed instruction retire without re-triggering the same breakpoint
  always_ff @(posedge i_oszClk) begin
    if (i_btnReset) begin
      bpMask        <= 1'b0;
      o_breakActive <= 1'b0;
    end else begin
      o_breakActive <= (nextState == BREAK);
      if (state == BREAK && nextState == RUN) bpMask <= 1'b1;
      else if (o_cpuClkEn && i_instrDone)     bpMask <= 1'b0;
    end
  end
`else
  assign o_breakActive = 1'b0;
`endif

endmodule

// File: tb/tb_step_controller.sv
// Directed + randomized bench for step_controller; the bench acts as the datapath
// and checks enable-pulse counts, widths and instruction boundaries.
module tb_step_controller;
  logic clk = 1'b0;
  logic i_btnReset = 1'b0, i_btnStep = 1'b0, i_swInstrNCycle = 1'b0, i_swStepNRun = 1'b1;
  logic i_swEnableBreakpoint = 1'b0, i_instrDone = 1'b0, i_breakpointHit = 1'b0;
  logic o_cpuClkEn, o_halted, o_breakActive;

  int total = 0, bad = 0;
  int enCount = 0, instrCount = 0, micro = 0, instrLen = 4;
  int curRun = 0, maxRun = 0, hitMode = 0, bpAt = 0;
  logic enCur = 1'b0;

  step_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .i_oszClk(clk), .i_btnReset(i_btnReset), .i_btnStep(i_btnStep),
    .i_swInstrNCycle(i_swInstrNCycle), .i_swStepNRun(i_swStepNRun),
    .i_swEnableBreakpoint(i_swEnableBreakpoint), .i_instrDone(i_instrDone),
    .i_breakpointHit(i_breakpointHit), .o_cpuClkEn(o_cpuClkEn),
    .o_halted(o_halted), .o_breakActive(o_breakActive)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: retire the cycle that ended into the datapath model, then sample outputs
  // and present the datapath signals for the new cycle.
  task automatic cyc();
    @(posedge clk);
    if (enCur) begin
      enCount++;
      if (i_instrDone) begin instrCount++; micro = 0; end
      else micro++;
    end
    #1;
    enCur = o_cpuClkEn;
    if (enCur) begin curRun++; if (curRun > maxRun) maxRun = curRun; end
    else curRun = 0;
    if (i_btnReset) begin micro = 0; instrCount = 0; end
    i_instrDone = enCur && (micro == instrLen - 1);
    i_breakpointHit = i_instrDone && ((hitMode == 2) || (hitMode == 1 && instrCount == bpAt));
  endtask

  task automatic press(input int bounces, input int seg, input int hold);
    for (int b = 0; b < bounces; b++) begin
      i_btnStep = 1'b1; repeat (seg > 0 ? seg : int'($urandom_range(1, 3))) cyc();
      i_btnStep = 1'b0; repeat (seg > 0 ? seg : int'($urandom_range(1, 3))) cyc();
    end
    i_btnStep = 1'b1; repeat (hold) cyc();
    i_btnStep = 1'b0; repeat (12) cyc();
  endtask

  task automatic waitHalted(input int budget);
    for (int i = 0; i < budget && !o_halted; i++) cyc();
  endtask

  initial begin
    int e0, n0, len;

    // reset state
    i_btnReset = 1'b1;
    repeat (3) cyc();
    chk("rst_en", o_cpuClkEn, 0);
    chk("rst_halted", o_halted, 1);
    chk("rst_brk", o_breakActive, 0);
    i_btnReset = 1'b0;
    repeat (6) cyc();
    chk("idle_en", o_cpuClkEn, 0);
    chk("idle_halted", o_halted, 1);

    // bouncy press in step/cycle mode: one pulse, one cycle wide
    e0 = enCount; maxRun = 0;
    press(2, 2, 10);
    chk("bounce_pulses", enCount - e0, 1);
    chk("bounce_width", maxRun, 1);
    chk("bounce_halted", o_halted, 1);

    for (int t = 0; t < 3; t++) begin
      e0 = enCount; maxRun = 0;
      press($urandom_range(0, 3), 0, 12);
      chk("cyc_pulses", enCount - e0, 1);
      chk("cyc_width", maxRun, 1);
    end

    // step/instruction mode, random instruction lengths
    i_swInstrNCycle = 1'b1;
    repeat (4) cyc();
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 8);
      instrLen = len; micro = 0;
      e0 = enCount; maxRun = 0;
      press($urandom_range(0, 3), 0, 12);
      waitHalted(20);
      chk("ins_cycles", enCount - e0, len);
      chk("ins_width", maxRun, len);
      chk("ins_halted", o_halted, 1);
    end

    // presses during a long instruction are ignored
    instrLen = 40; micro = 0; e0 = enCount;
    i_btnStep = 1'b1; repeat (12) cyc();
    i_btnStep = 1'b0; repeat (8) cyc();
    i_btnStep = 1'b1; repeat (8) cyc();
    i_btnStep = 1'b0;
    waitHalted(60);
    repeat (20) cyc();
    chk("ignore_press", enCount - e0, 40);

    // run mode from reset release, then stop in cycle mode
    i_swStepNRun = 1'b0; i_swInstrNCycle = 1'b0; instrLen = 4;
    i_btnReset = 1'b1; repeat (3) cyc(); i_btnReset = 1'b0;
    cyc(); chk("run_c1", o_cpuClkEn, 0);
    cyc(); chk("run_c2", o_cpuClkEn, 0);
    cyc(); chk("run_c3", o_cpuClkEn, 1);
    e0 = enCount;
    repeat (30) cyc();
    chk("run_cont", enCount - e0, 30);
    i_swStepNRun = 1'b1;
    repeat (3) cyc();
    chk("stop_c3", o_cpuClkEn, 0);
    e0 = enCount;
    repeat (10) cyc();
    chk("stop_stays", enCount - e0, 0);

    // leaving run in instruction mode stops on an instruction boundary
    instrLen = 5; micro = 0;
    i_swStepNRun = 1'b0;
    repeat ($urandom_range(8, 20)) cyc();
    i_swStepNRun = 1'b1; i_swInstrNCycle = 1'b1;
    repeat (3) cyc();
    waitHalted(40);
    chk("ins_stop_halted", o_halted, 1);
    chk("ins_boundary", micro, 0);

    // breakpoint behaviour
    i_swInstrNCycle = 1'b0; i_swEnableBreakpoint = 1'b1;
    instrLen = 3; micro = 0;
`ifdef STEP_BREAKPOINT_EN
    hitMode = 1; bpAt = instrCount + int'($urandom_range(1, 4));
    i_swStepNRun = 1'b0;
    for (int i = 0; i < 200 && !o_breakActive; i++) cyc();
    chk("bp_active", o_breakActive, 1);
    chk("bp_en_low", o_cpuClkEn, 0);
    chk("bp_instr", instrCount, bpAt + 1);
    e0 = enCount;
    repeat (5) cyc();
    chk("bp_holds", enCount - e0, 0);
    hitMode = 2; n0 = instrCount;
    press(0, 0, 12);
    for (int i = 0; i < 100 && !o_breakActive; i++) cyc();
    chk("bp_rebreak", o_breakActive, 1);
    chk("bp_masked_one", instrCount - n0, 2);
    i_swStepNRun = 1'b1;
    repeat (4) cyc();
    chk("bp_exit_halted", o_halted, 1);
    chk("bp_exit_brk", o_breakActive, 0);
`else
    hitMode = 2; n0 = 0;
    i_swStepNRun = 1'b0;
    repeat (4) cyc();
    e0 = enCount;
    repeat (40) cyc();
    chk("nobp_run", enCount - e0 + n0, 40);
    chk("nobp_brk", o_breakActive, 0);
    i_swStepNRun = 1'b1;
    repeat (4) cyc();
    chk("nobp_exit_halted", o_halted, 1);
`endif
    hitMode = 0; i_swEnableBreakpoint = 1'b0;

    // reset mid-instruction with the button held through it
    i_swInstrNCycle = 1'b1; instrLen = 50; micro = 0;
    repeat (4) cyc();
    i_btnStep = 1'b1;
    for (int i = 0; i < 30 && !o_cpuClkEn; i++) cyc();
    chk("held_started", o_cpuClkEn, 1);
    repeat (3) cyc();
    i_btnReset = 1'b1;
    cyc();
    chk("midrst_en", o_cpuClkEn, 0);
    chk("midrst_halted", o_halted, 1);
    cyc();
    i_btnReset = 1'b0;
    e0 = enCount;
    repeat (25) cyc();
    chk("held_nopress", enCount - e0, 0);
    i_btnStep = 1'b0;
    repeat (12) cyc();
    instrLen = 2; micro = 0; e0 = enCount;
    press(0, 0, 12);
    waitHalted(20);
    chk("repress_cycles", enCount - e0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
